// File: rtl/mem_arb_pkg.sv
// Shared types, port ids and range check for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int MEM_BYTES_DEF = 128;

   // One extra bit keeps addresses near the top of the space from wrapping.
   function automatic logic in_range(
      input logic [31:0] addr,
      input logic        byte_op,
      input int unsigned mem_bytes
   );
      logic [32:0] last;
      last = {1'b0, addr} + (byte_op ? 33'd0 : 33'd3);
      return last < {1'b0, mem_bytes};
   endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and data ports.
// Policy: fixed D-over-I, or alternation when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_grant,
   output logic grant,
   output logic valid
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      valid = i_req | d_req;
      grant = PORT_I;
      if (i_req && d_req) begin
         grant = ~last_grant;
      end else if (d_req) begin
         grant = PORT_D;
      end
   end
`else
   logic lg_unused;
   assign lg_unused = last_grant;

   always_comb begin
      valid = i_req | d_req;
      grant = d_req ? PORT_D : PORT_I;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialising arbiter in front of the shared byte-addressed memory.
// Contention policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_byte,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_byte,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_t state, state_nxt;

   logic last_grant;
   logic grant;
   logic grant_vld;
   logic sel_port;
   logic sel_we;
   logic sel_byte;

   logic              req_ok;
   logic              req_we;
   logic              req_byte;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] rd_val;

   mem_arb_grant u_grant (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant      (grant),
      .valid      (grant_vld)
   );

   always_comb begin
      req_addr = (grant == PORT_D) ? d_addr : i_addr;
      req_we   = (grant == PORT_D) && d_we;
      req_byte = (grant == PORT_D) && d_byte;
      req_ok   = in_range(32'(req_addr), req_byte, MEM_BYTES);
   end

   always_comb begin
      rd_val = '0;
      if (!sel_we) begin
         rd_val = sel_byte ?
            {{(DATA_W-8){1'b0}}, mem_read_data[7:0]} :
            mem_read_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_byte  = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = req_ok ? ACCESS : DONE;
            end
         end
         ACCESS: begin
            mem_read  = ~sel_we;
            mem_write = sel_we;
            mem_byte  = sel_byte;
            state_nxt = DONE;
         end
         DONE: begin
            i_ack     = (sel_port == PORT_I);
            d_ack     = (sel_port == PORT_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Out-of-range grants skip ACCESS, so their result is loaded at grant time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant     <= PORT_I;
         sel_port       <= PORT_I;
         sel_we         <= 1'b0;
         sel_byte       <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         i_rdata        <= '0;
         i_err          <= 1'b0;
         d_rdata        <= '0;
         d_err          <= 1'b0;
      end else begin
         if (state == IDLE && grant_vld) begin
            last_grant <= grant;
            sel_port   <= grant;
            sel_we     <= req_we;
            sel_byte   <= req_byte;
            if (req_ok) begin
               mem_address <= req_addr;
               if (req_we) begin
                  mem_write_data <= d_wdata;
               end
            end else if (grant == PORT_D) begin
               d_rdata <= '0;
               d_err   <= 1'b1;
            end else begin
               i_rdata <= '0;
               i_err   <= 1'b1;
            end
         end
         if (state == ACCESS) begin
            if (sel_port == PORT_D) begin
               d_rdata <= rd_val;
               d_err   <= 1'b0;
            end else begin
               i_rdata <= rd_val;
               i_err   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences,
// random traffic against a transaction-level memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [17:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic        d_byte;
   logic [17:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [17:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic        mem_byte;
   logic [31:0] mem_read_data;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem     [0:127];
   logic [7:0]  ref_mem [0:127];
   logic [31:0] last_i_exp;
   logic [31:0] last_d_exp;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_ack          (i_ack),
      .i_rdata        (i_rdata),
      .i_err          (i_err),
      .d_req          (d_req),
      .d_we           (d_we),
      .d_byte         (d_byte),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_ack          (d_ack),
      .d_rdata        (d_rdata),
      .d_err          (d_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_byte       (mem_byte),
      .mem_read_data  (mem_read_data)
   );

   // Environment memory: combinational read, clocked write.
   logic [6:0] ma;
   assign ma = mem_address[6:0];
   assign mem_read_data = {mem[ma + 7'd3], mem[ma + 7'd2],
                           mem[ma + 7'd1], mem[ma]};

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i]     = 8'(i) ^ 8'hA5;
         ref_mem[i] = 8'(i) ^ 8'hA5;
      end
   end

   always @(posedge clk) begin
      if (mem_write) begin
         mem[ma] <= mem_write_data[7:0];
         if (!mem_byte) begin
            mem[ma + 7'd1] <= mem_write_data[15:8];
            mem[ma + 7'd2] <= mem_write_data[23:16];
            mem[ma + 7'd3] <= mem_write_data[31:24];
         end
      end
   end

   logic any_out;
   assign any_out = |{i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
                      mem_address, mem_write_data,
                      mem_read, mem_write, mem_byte};

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference model: spec rules in plain integer arithmetic.
   function automatic bit ref_ok(input logic [17:0] a, input bit bt);
      return (int'(a) + (bt ? 0 : 3)) < 128;
   endfunction

   function automatic logic [31:0] ref_word(input int a);
      return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
   endfunction

   function automatic logic [31:0] ref_read(input bit we, input bit bt,
                                            input logic [17:0] a);
      if (!ref_ok(a, bt) || we) return 32'h0;
      if (bt) return {24'h0, ref_mem[int'(a)]};
      return ref_word(int'(a));
   endfunction

   task automatic ref_apply(input bit we, input bit bt,
                            input logic [17:0] a, input logic [31:0] wd);
      if (we && ref_ok(a, bt)) begin
         ref_mem[int'(a)] = wd[7:0];
         if (!bt) begin
            ref_mem[int'(a)+1] = wd[15:8];
            ref_mem[int'(a)+2] = wd[23:16];
            ref_mem[int'(a)+3] = wd[31:24];
         end
      end
   endtask

   task automatic do_reset();
      i_req  = 1'b0;
      d_req  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last_i_exp = 32'h0;
      last_d_exp = 32'h0;
   endtask

   task automatic run(input string nm, input bit port, input bit we,
                      input bit bt, input logic [17:0] addr,
                      input logic [31:0] wd, input logic [31:0] e_rd,
                      input bit e_err, input int e_lat, input int e_wr,
                      input int e_rdn, input int e_by);
      logic [31:0] rd;
      bit er;
      bit tmo;
      int lat, nwr, nrd, nby, noth, nbad;
      @(negedge clk);
      if (port) begin
         d_req   = 1'b1;
         d_we    = we;
         d_byte  = bt;
         d_addr  = addr;
         d_wdata = wd;
      end else begin
         i_req  = 1'b1;
         i_addr = addr;
      end
      rd = 32'h0; er = 1'b0; tmo = 1'b1;
      lat = 0; nwr = 0; nrd = 0; nby = 0; noth = 0; nbad = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         nwr += int'(mem_write);
         nrd += int'(mem_read);
         nby += int'(mem_byte);
         if ((mem_read || mem_write) && mem_address != addr) nbad++;
         if (mem_write && (!port || mem_write_data[7:0] != wd[7:0] ||
             (!bt && mem_write_data != wd))) nbad++;
         if (port ? i_ack : d_ack) noth++;
         if (port ? d_ack : i_ack) begin
            lat = c;
            rd  = port ? d_rdata : i_rdata;
            er  = port ? d_err : i_err;
            tmo = 1'b0;
            break;
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      if (tmo) chk({nm, "_timeout"}, 32'd1, 32'd0);
      chk({nm, "_rdata"}, rd, e_rd);
      chk({nm, "_err"}, 32'(er), 32'(e_err));
      chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
      chk({nm, "_wr_cyc"}, 32'(nwr), 32'(e_wr));
      chk({nm, "_rd_cyc"}, 32'(nrd), 32'(e_rdn));
      chk({nm, "_byte_cyc"}, 32'(nby), 32'(e_by));
      chk({nm, "_other_ack"}, 32'(noth), 32'd0);
      chk({nm, "_bus"}, 32'(nbad), 32'd0);
      if (port) begin
         chk({nm, "_i_hold"}, i_rdata, last_i_exp);
         last_d_exp = e_rd;
      end else begin
         chk({nm, "_d_hold"}, d_rdata, last_d_exp);
         last_i_exp = e_rd;
      end
   endtask

   typedef struct {
      bit          port;
      bit          we;
      bit          bt;
      logic [17:0] addr;
      logic [31:0] wd;
      logic [31:0] e_rd;
      bit          e_err;
      int          e_lat;
      int          e_wr;
      int          e_rdn;
      int          e_by;
   } vec_t;

   vec_t vecs [13];
   bit   exp_order [4];
   bit   order [4];

   initial begin
      int   got;
      bit   seen;
      bit   port, we, bt;
      logic [17:0] a;
      logic [31:0] wd;
      bit   ok;

      reset   = 1'b1;
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_byte  = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      last_i_exp = 32'h0;
      last_d_exp = 32'h0;

      repeat (2) @(negedge clk);
      chk("reset_outs", 32'(any_out), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_outs", 32'(any_out), 32'd0);

      //         port we bt addr        wdata         exp_rd  err lat wr rd by
      vecs[0]  = '{1, 1, 0, 18'h00010, 32'hDEADBEEF, 32'h0,        0, 2, 1, 0, 0};
      vecs[1]  = '{1, 0, 0, 18'h00010, 32'h0,        32'hDEADBEEF, 0, 2, 0, 1, 0};
      vecs[2]  = '{1, 0, 1, 18'h00011, 32'h0,        32'h000000BE, 0, 2, 0, 1, 1};
      vecs[3]  = '{0, 0, 0, 18'd125,   32'h0,        32'h0,        1, 1, 0, 0, 0};
      vecs[4]  = '{1, 0, 1, 18'd127,   32'h0,        32'h000000DA, 0, 2, 0, 1, 1};
      vecs[5]  = '{1, 0, 0, 18'h3FFFF, 32'h0,        32'h0,        1, 1, 0, 0, 0};
      vecs[6]  = '{1, 1, 1, 18'h00013, 32'hFFFFFF55, 32'h0,        0, 2, 1, 0, 1};
      vecs[7]  = '{1, 0, 0, 18'h00010, 32'h0,        32'h55ADBEEF, 0, 2, 0, 1, 0};
      vecs[8]  = '{0, 0, 0, 18'd124,   32'h0,        32'hDADBD8D9, 0, 2, 0, 1, 0};
      vecs[9]  = '{1, 0, 0, 18'd125,   32'h0,        32'h0,        1, 1, 0, 0, 0};
      vecs[10] = '{0, 0, 0, 18'd0,     32'h0,        32'hA6A7A4A5, 0, 2, 0, 1, 0};
      vecs[11] = '{1, 1, 1, 18'd128,   32'h12345678, 32'h0,        1, 1, 0, 0, 0};
      vecs[12] = '{1, 0, 0, 18'h3FFFD, 32'h0,        32'h0,        1, 1, 0, 0, 0};

      for (int k = 0; k < 13; k++) begin
         run($sformatf("vec%0d", k), vecs[k].port, vecs[k].we, vecs[k].bt,
             vecs[k].addr, vecs[k].wd, vecs[k].e_rd, vecs[k].e_err,
             vecs[k].e_lat, vecs[k].e_wr, vecs[k].e_rdn, vecs[k].e_by);
         ref_apply(vecs[k].we, vecs[k].bt, vecs[k].addr, vecs[k].wd);
      end

      // Reset during the ACCESS cycle of a D read.
      @(negedge clk);
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_byte = 1'b0;
      d_addr = 18'h10;
      @(negedge clk);
      chk("rst_mid_rd_strobe", 32'(mem_read), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_outs", 32'(any_out), 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      last_i_exp = 32'h0;
      last_d_exp = 32'h0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen |= d_ack | i_ack | mem_read | mem_write;
      end
      chk("rst_mid_no_ack", 32'(seen), 32'd0);
      run("post_rst", 1, 0, 0, 18'h10, 32'h0, ref_word(16), 0, 2, 0, 1, 0);

      // Contention with both requests held for four grants.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{1, 0, 1, 0};
`else
      exp_order = '{1, 1, 1, 1};
`endif
      do_reset();
      @(negedge clk);
      i_req  = 1'b1;
      i_addr = 18'h0;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_byte = 1'b0;
      d_addr = 18'h10;
      got = 0;
      order = '{0, 0, 0, 0};
      for (int c = 0; c < 30 && got < 4; c++) begin
         @(negedge clk);
         if (i_ack && d_ack) begin
            chk("cont_both_ack", 32'd1, 32'd0);
         end else if (d_ack) begin
            chk("cont_d_rdata", d_rdata, ref_word(16));
            order[got] = 1'b1;
            got++;
         end else if (i_ack) begin
            chk("cont_i_rdata", i_rdata, ref_word(0));
            order[got] = 1'b0;
            got++;
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      chk("cont_grants", 32'(got), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("cont_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      end
      for (int k = 0; k < 4; k++) begin
         if (exp_order[k]) last_d_exp = ref_word(16);
         else last_i_exp = ref_word(0);
      end

      // Random single-requester traffic against the model.
      for (int n = 0; n < 60; n++) begin
         port = 1'($urandom_range(0, 1));
         we   = port ? 1'($urandom_range(0, 1)) : 1'b0;
         bt   = port ? 1'($urandom_range(0, 1)) : 1'b0;
         if ($urandom_range(0, 9) == 0) a = 18'($urandom);
         else a = 18'($urandom_range(0, 131));
         wd = $urandom;
         ok = ref_ok(a, bt);
         run($sformatf("rnd%0d", n), port, we, bt, a, wd,
             ref_read(we, bt, a), !ok, ok ? 2 : 1,
             (ok && we) ? 1 : 0, (ok && !we) ? 1 : 0,
             (ok && bt) ? 1 : 0);
         ref_apply(we, bt, a, wd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
